// File: rtl/pe_array_sequencer.sv
// rtl/pe_array_sequencer.sv - shadow-buffered control word and enable sequencer for a PE row
// Optional busy-cycle counter output is built only when PE_SEQ_BUSY_CNT_EN is defined.
module pe_array_sequencer #(
  parameter int NUM_PE = 4,
  parameter int CNT_W  = 8,
  localparam int PTR_W = $clog2(NUM_PE)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [7:0]          cfg_data,
  input  logic                start,
  input  logic [CNT_W-1:0]    run_len,
  input  logic                abort,
  output logic [8*NUM_PE-1:0] pe_ctrl,
  output logic [NUM_PE-1:0]   pe_en,
  output logic [PTR_W-1:0]    cfg_ptr,
  output logic                busy,
  output logic                done
`ifdef PE_SEQ_BUSY_CNT_EN
  ,
  output logic [15:0]         busy_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             cfg_wr;

  // cfg_ready is only ever high in IDLE, so the handshake alone implies IDLE.
  assign cfg_wr = cfg_valid & cfg_ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_next   = run_len;
          state_next = (run_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so every one of them is a flop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cfg_ready <= 1'b0;
      pe_en     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ptr   <= '0;
      pe_ctrl   <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cfg_ready <= (state_next == IDLE);
      pe_en     <= {NUM_PE{state_next == RUN}};
      busy      <= (state_next == RUN);
      done      <= (state_next == DONE);
      if (cfg_wr) begin
        for (int i = 0; i < NUM_PE; i++) begin
          if (cfg_ptr == PTR_W'(i)) begin
            pe_ctrl[8*i +: 8] <= cfg_data;
          end
        end
        if (cfg_ptr == PTR_W'(NUM_PE - 1)) begin
          cfg_ptr <= '0;
        end else begin
          cfg_ptr <= cfg_ptr + PTR_W'(1);
        end
      end
    end
  end

`ifdef PE_SEQ_BUSY_CNT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_cycles <= '0;
    end else if (busy && (busy_cycles != 16'hFFFF)) begin
      busy_cycles <= busy_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_array_sequencer.sv
// tb/tb_pe_array_sequencer.sv - directed bench for pe_array_sequencer with a cycle-window reference model
module tb_pe_array_sequencer;
  localparam int NUM_PE = 4;
  localparam int CNT_W  = 8;

  logic                clock;
  logic                reset;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [7:0]          cfg_data;
  logic                start;
  logic [CNT_W-1:0]    run_len;
  logic                abort;
  logic [8*NUM_PE-1:0] pe_ctrl;
  logic [NUM_PE-1:0]   pe_en;
  logic [1:0]          cfg_ptr;
  logic                busy;
  logic                done;
`ifdef PE_SEQ_BUSY_CNT_EN
  logic [15:0]         busy_cycles;
`endif

  pe_array_sequencer #(.NUM_PE(NUM_PE), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_data    (cfg_data),
    .start       (start),
    .run_len     (run_len),
    .abort       (abort),
    .pe_ctrl     (pe_ctrl),
    .pe_en       (pe_en),
    .cfg_ptr     (cfg_ptr),
    .busy        (busy),
    .done        (done)
`ifdef PE_SEQ_BUSY_CNT_EN
    ,
    .busy_cycles (busy_cycles)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model: cycle k is the period following edge k-1; a run is a window of cycle numbers.
  int         n_vec;
  int         n_fail;
  int         cyc;
  logic [7:0] m_slot [NUM_PE];
  int         m_ptr;
  int         en_lo;
  int         en_hi;
  int         done_cyc;
  int         idle_from;
  int         m_bc;
  int         en_count;
  int         done_count;
  logic [7:0] last_ctrl0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc + 1);
    end
  endtask

  task automatic model_edge();
    int  cur;
    bit  in_run;
    bit  idle_now;
    bit  ready_now;
    cur = cyc + 1;
    if (!reset) begin
      for (int i = 0; i < NUM_PE; i++) m_slot[i] = 8'h00;
      m_ptr     = 0;
      en_lo     = 1;
      en_hi     = 0;
      done_cyc  = 0;
      idle_from = cur + 2;
      m_bc      = 0;
    end else begin
      in_run    = (cur >= en_lo) && (cur <= en_hi);
      idle_now  = !in_run && (cur != done_cyc);
      ready_now = (cur >= idle_from);
      if (in_run && m_bc < 65535) m_bc++;
      if (ready_now && cfg_valid) begin
        m_slot[m_ptr] = cfg_data;
        m_ptr = (m_ptr + 1) % NUM_PE;
      end
      if (in_run && abort) begin
        en_hi     = cur;
        idle_from = cur + 1;
      end else if (idle_now && start) begin
        if (run_len != 0) begin
          en_lo     = cur + 1;
          en_hi     = cur + int'(run_len);
          done_cyc  = cur + int'(run_len) + 1;
          idle_from = cur + int'(run_len) + 2;
        end else begin
          done_cyc  = cur + 1;
          idle_from = cur + 2;
        end
      end
    end
  endtask

  task automatic compare_cycle();
    int                  k;
    bit                  run_k;
    logic [8*NUM_PE-1:0] exp_ctrl;
    k     = cyc + 1;
    run_k = (k >= en_lo) && (k <= en_hi);
    for (int i = 0; i < NUM_PE; i++) exp_ctrl[8*i +: 8] = m_slot[i];
    check("pe_en", 64'(pe_en), run_k ? 64'hF : 64'h0);
    check("busy", 64'(busy), 64'(run_k));
    check("done", 64'(done), 64'(k == done_cyc));
    check("cfg_ready", 64'(cfg_ready), 64'(k >= idle_from));
    check("pe_ctrl", 64'(pe_ctrl), 64'(exp_ctrl));
    check("cfg_ptr", 64'(cfg_ptr), 64'(m_ptr));
`ifdef PE_SEQ_BUSY_CNT_EN
    check("busy_cycles", 64'(busy_cycles), 64'(m_bc));
`endif
    if (pe_en != '0) begin
      en_count++;
      last_ctrl0 = pe_ctrl[7:0];
    end
    if (done) done_count++;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    cyc++;
    @(negedge clock);
    compare_cycle();
  endtask

  task automatic push(input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_data  = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic run(input logic [CNT_W-1:0] n, input int settle);
    start   = 1'b1;
    run_len = n;
    tick();
    start = 1'b0;
    repeat (settle) tick();
  endtask

  int  e0;
  int  d0;
  bit  acc;

  initial begin
    n_vec = 0; n_fail = 0; cyc = 0;
    en_count = 0; done_count = 0; last_ctrl0 = 8'h00;
    en_lo = 1; en_hi = 0; done_cyc = 0; idle_from = 1 << 30; m_ptr = 0; m_bc = 0;
    for (int i = 0; i < NUM_PE; i++) m_slot[i] = 8'h00;
    reset = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00; start = 1'b0; run_len = '0; abort = 1'b0;
    @(negedge clock);

    // Reset with random inputs
    repeat (2) begin
      cfg_valid = 1'($urandom); start = 1'($urandom); abort = 1'($urandom);
      cfg_data = 8'($urandom); run_len = CNT_W'($urandom);
      tick();
    end
    check("rst_pe_en", 64'(pe_en), 64'h0);
    check("rst_pe_ctrl", 64'(pe_ctrl), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_cfg_ptr", 64'(cfg_ptr), 64'h0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'h0);
    reset = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0; run_len = '0;
    tick();
    check("rel_cfg_ready", 64'(cfg_ready), 64'h1);

    // Load and wrap
    push(8'hA1); push(8'h52); push(8'h13); push(8'hFF); push(8'h07);
    check("wrap_pe_ctrl", 64'(pe_ctrl), 64'hFF13_5207);
    check("wrap_cfg_ptr", 64'(cfg_ptr), 64'h1);

    // Run of 5
    e0 = en_count; d0 = done_count;
    run(8'd5, 8);
    check("run5_en_cycles", 64'(en_count - e0), 64'd5);
    check("run5_done", 64'(done_count - d0), 64'd1);

    // Zero length
    e0 = en_count; d0 = done_count;
    run(8'd0, 3);
    check("zero_en_cycles", 64'(en_count - e0), 64'd0);
    check("zero_done", 64'(done_count - d0), 64'd1);

    // Abort on the third RUN cycle
    e0 = en_count; d0 = done_count;
    run(8'd10, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    check("abort_en_cycles", 64'(en_count - e0), 64'd3);
    check("abort_done", 64'(done_count - d0), 64'd0);
`ifdef PE_SEQ_BUSY_CNT_EN
    check("busy_cycles_8", 64'(busy_cycles), 64'd8);
`endif
    e0 = en_count; d0 = done_count;
    run(8'd2, 4);
    check("post_abort_en", 64'(en_count - e0), 64'd2);
    check("post_abort_done", 64'(done_count - d0), 64'd1);

    // Same-cycle write to slot 0 plus start
    push(8'h11); push(8'h22); push(8'h33);
    check("ptr_back_to_0", 64'(cfg_ptr), 64'h0);
    cfg_valid = 1'b1; cfg_data = 8'h3C;
    e0 = en_count;
    run(8'd1, 0);
    cfg_valid = 1'b0;
    repeat (3) tick();
    check("same_cycle_en", 64'(en_count - e0), 64'd1);
    check("same_cycle_ctrl0", 64'(last_ctrl0), 64'h3C);

    // Config offered during RUN stalls until IDLE
    start = 1'b1; run_len = 8'd4;
    tick();
    start = 1'b0;
    cfg_valid = 1'b1; cfg_data = 8'h5A;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = cfg_ready;
      tick();
    end
    cfg_valid = 1'b0;
    check("stall_accepted", 64'(acc), 64'h1);
    check("stall_slot1", 64'(pe_ctrl[15:8]), 64'h5A);
    check("stall_cfg_ptr", 64'(cfg_ptr), 64'h2);
    tick();

    // Full-range run length
    e0 = en_count; d0 = done_count;
    run(8'd255, 257);
    check("max_en_cycles", 64'(en_count - e0), 64'd255);
    check("max_done", 64'(done_count - d0), 64'd1);

    // Reset in the middle of a run
    run(8'd6, 1);
    reset = 1'b0;
    tick();
    check("midrst_pe_ctrl", 64'(pe_ctrl), 64'h0);
    check("midrst_cfg_ptr", 64'(cfg_ptr), 64'h0);
    check("midrst_pe_en", 64'(pe_en), 64'h0);
`ifdef PE_SEQ_BUSY_CNT_EN
    check("midrst_busy_cycles", 64'(busy_cycles), 64'h0);
`endif
    reset = 1'b1;
    repeat (2) tick();
    check("midrst_cfg_ready", 64'(cfg_ready), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
